// File: rtl/ifu_idu_queue.sv
// In-order fetch-to-decode instruction queue (circular buffer) with redirect flush.
// Optional same-cycle empty-queue forwarding is enabled by defining IFU_IDU_QUEUE_BYPASS_EN.
module ifu_idu_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  r_pc_mem   [DEPTH];
  logic [XLEN-1:0]  r_inst_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_q_valid;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  // Handshake qualifiers depend only on registered state, flush and reset.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == CNT_W'(0));
  assign in_ready  = ~w_full & ~flush & rst;
  assign w_q_valid = ~w_empty & ~flush;
  assign count     = r_count;

`ifdef IFU_IDU_QUEUE_BYPASS_EN
  // Empty queue with a waiting consumer: forward fetch directly, nothing is stored.
  assign w_bypass  = rst & w_empty & in_valid & out_ready & ~flush;
  assign out_valid = w_q_valid | w_bypass;
  assign out_pc    = w_bypass ? in_pc   : r_pc_mem[r_rd_ptr];
  assign out_inst  = w_bypass ? in_inst : r_inst_mem[r_rd_ptr];
`else
  assign w_bypass  = 1'b0;
  assign out_valid = w_q_valid;
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_inst  = r_inst_mem[r_rd_ptr];
`endif

  assign w_push = in_valid & in_ready & ~w_bypass;
  assign w_pop  = w_q_valid & out_ready;

  // Next pointer/occupancy; flush wins over any handshake in the same cycle.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_wr_ptr_nxt = PTR_W'(0);
      w_rd_ptr_nxt = PTR_W'(0);
      w_count_nxt  = CNT_W'(0);
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage is cleared only by reset so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[PTR_W'(i)]   <= '0;
        r_inst_mem[PTR_W'(i)] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Directed bench for ifu_idu_queue: vector table plus streaming, latency and async-reset sequences.
module tb_ifu_idu_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  ifu_idu_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_cnt;
    logic        chk;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] pc,
                              input logic [31:0] inst, input logic ordy, input logic fl,
                              input logic e_ir, input logic e_ov, input logic [2:0] e_cnt,
                              input logic chk, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rst = r;   v.iv = iv;     v.pc = pc;       v.inst = inst;  v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.chk = chk; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [31:0] q_pc   [$];
  logic [31:0] q_inst [$];
  logic        exp_ov;
  logic [2:0]  exp_cnt;
  int          got;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset hold, fill, full-with-pop, drain order, flush and post-flush push.
    vecs[0]  = mk(0, 1, 32'h80000000, 32'h00000113, 0, 0,  0, 0, 3'd0, 1, 32'h0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h80000000, 32'h00000113, 0, 0,  0, 0, 3'd0, 1, 32'h0, 32'h0);
    vecs[2]  = mk(0, 1, 32'h80000000, 32'h00000113, 0, 0,  0, 0, 3'd0, 1, 32'h0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0,        32'h0,        0, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);
    vecs[4]  = mk(1, 1, 32'h80000000, 32'h00000113, 0, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);
    vecs[5]  = mk(1, 1, 32'h80000004, 32'h00000213, 0, 0,  1, 1, 3'd1, 1, 32'h80000000, 32'h00000113);
    vecs[6]  = mk(1, 1, 32'h80000008, 32'h00000313, 0, 0,  1, 1, 3'd2, 1, 32'h80000000, 32'h00000113);
    vecs[7]  = mk(1, 1, 32'h8000000C, 32'h00000413, 0, 0,  1, 1, 3'd3, 1, 32'h80000000, 32'h00000113);
    vecs[8]  = mk(1, 1, 32'h80000010, 32'h00000513, 0, 0,  0, 1, 3'd4, 1, 32'h80000000, 32'h00000113);
    vecs[9]  = mk(1, 1, 32'h80000010, 32'h00000513, 1, 0,  0, 1, 3'd4, 1, 32'h80000000, 32'h00000113);
    vecs[10] = mk(1, 0, 32'h0,        32'h0,        1, 0,  1, 1, 3'd3, 1, 32'h80000004, 32'h00000213);
    vecs[11] = mk(1, 0, 32'h0,        32'h0,        1, 0,  1, 1, 3'd2, 1, 32'h80000008, 32'h00000313);
    vecs[12] = mk(1, 0, 32'h0,        32'h0,        1, 0,  1, 1, 3'd1, 1, 32'h8000000C, 32'h00000413);
    vecs[13] = mk(1, 0, 32'h0,        32'h0,        1, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);
    vecs[14] = mk(1, 1, 32'h80000040, 32'h00000613, 0, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);
    vecs[15] = mk(1, 1, 32'h80000044, 32'h00000713, 0, 0,  1, 1, 3'd1, 1, 32'h80000040, 32'h00000613);
    vecs[16] = mk(1, 1, 32'h80000048, 32'h00000813, 0, 0,  1, 1, 3'd2, 1, 32'h80000040, 32'h00000613);
    vecs[17] = mk(1, 1, 32'h80000050, 32'h00000913, 1, 1,  0, 0, 3'd3, 0, 32'h0, 32'h0);
    vecs[18] = mk(1, 1, 32'h80000100, 32'h00000A13, 0, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);
    vecs[19] = mk(1, 0, 32'h0,        32'h0,        0, 0,  1, 1, 3'd1, 1, 32'h80000100, 32'h00000A13);
    vecs[20] = mk(1, 0, 32'h0,        32'h0,        1, 0,  1, 1, 3'd1, 1, 32'h80000100, 32'h00000A13);
    vecs[21] = mk(1, 0, 32'h0,        32'h0,        0, 0,  1, 0, 3'd0, 0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_pc = vecs[i].pc; in_inst = vecs[i].inst;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #1;
      check($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("row%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
      if (vecs[i].chk) begin
        check($sformatf("row%0d out_pc", i),   out_pc,   vecs[i].e_pc);
        check($sformatf("row%0d out_inst", i), out_inst, vecs[i].e_inst);
      end
    end

    // Empty-queue latency: same cycle with forwarding, one cycle later without.
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h80000020; in_inst = 32'h00000B13; out_ready = 1'b1; flush = 1'b0;
    #1;
`ifdef IFU_IDU_QUEUE_BYPASS_EN
    check("lat0 out_valid", 32'(out_valid), 32'd1);
    check("lat0 out_pc", out_pc, 32'h80000020);
    check("lat0 count", 32'(count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat1 out_valid", 32'(out_valid), 32'd0);
    check("lat1 count", 32'(count), 32'd0);
`else
    check("lat0 out_valid", 32'(out_valid), 32'd0);
    check("lat0 count", 32'(count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat1 out_valid", 32'(out_valid), 32'd1);
    check("lat1 out_pc", out_pc, 32'h80000020);
    check("lat1 count", 32'(count), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("lat2 out_valid", 32'(out_valid), 32'd0);
    check("lat2 count", 32'(count), 32'd0);
`endif

    // Streaming 10 entries back-to-back across pointer wrap, scoreboarded.
    got = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 10) begin
        in_valid = 1'b1;
        in_pc    = 32'h80000200 + 32'(4 * c);
        in_inst  = 32'h00000013 + 32'(c);
        q_pc.push_back(in_pc);
        q_inst.push_back(in_inst);
      end else begin
        in_valid = 1'b0;
      end
`ifdef IFU_IDU_QUEUE_BYPASS_EN
      exp_ov  = (c < 10);
      exp_cnt = 3'd0;
`else
      exp_ov  = (c >= 1) && (c <= 10);
      exp_cnt = exp_ov ? 3'd1 : 3'd0;
`endif
      #1;
      if (c < 10) check($sformatf("strm%0d in_ready", c), 32'(in_ready), 32'd1);
      check($sformatf("strm%0d out_valid", c), 32'(out_valid), 32'(exp_ov));
      check($sformatf("strm%0d count", c), 32'(count), 32'(exp_cnt));
      if (exp_ov && q_pc.size() != 0) begin
        check($sformatf("strm%0d out_pc", c), out_pc, q_pc.pop_front());
        check($sformatf("strm%0d out_inst", c), out_inst, q_inst.pop_front());
        got++;
      end
    end
    check("strm delivered", 32'(got), 32'd10);

    // Reset asserted asynchronously mid-cycle while entries are held.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h80000300; in_inst = 32'h00000C13;
    @(negedge clk);
    in_pc = 32'h80000304; in_inst = 32'h00000D13;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("arst pre count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst count", 32'(count), 32'd0);
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd0);
    check("arst out_pc", out_pc, 32'h0);
    check("arst out_inst", out_inst, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst rel in_ready", 32'(in_ready), 32'd1);
    check("arst rel count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
